// File: rtl/burst_pack_pkg.sv
// Shared types and constants for the burst word packer.
//   state_t      : packer FSM states (CSUM only reached with BURST_WORD_PACKER_CHECKSUM_EN)
//   MAX_BURST    : longest burst the upstream stage produces, in bytes
//   BYTE_W       : width of one input byte
//   count_width(): bits needed to hold a byte count 0..n
package burst_pack_pkg;

    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned BYTE_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_CSUM  = 2'd3
    } state_t;

    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO holding packed output words.
// Ports:
//   clk, reset     : rising-edge clock, synchronous active-low reset
//   i_push, i_data : write request and entry (dropped when full unless popping)
//   i_pop          : read request (ignored when empty)
//   o_data         : head entry
//   o_full/o_empty : occupancy flags
//   o_empty_nxt    : empty flag as it will be after this cycle's push/pop
module word_fifo
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_empty_nxt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic             w_wr_en;
    logic             w_rd_en;

    // Extra pointer MSB distinguishes full from empty.
    assign o_empty     = (r_wr == r_rd);
    assign o_full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_rd_en     = i_pop & ~o_empty;
    // A pop frees the slot, so a push while full is accepted alongside it.
    assign w_wr_en     = i_push & (~o_full | w_rd_en);
    assign o_empty_nxt = ((r_wr + PW'(w_wr_en)) == (r_rd + PW'(w_rd_en)));
    assign o_data      = r_mem[r_rd[AW-1:0]];

    // Storage and pointers; storage cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr[AW-1:0]] <= i_data;
                r_wr                <= r_wr + PW'(1);
            end
            if (w_rd_en) begin
                r_rd <= r_rd + PW'(1);
            end
        end
    end

endmodule

// File: rtl/burst_word_packer.sv
// Packs an unstallable byte burst into WORD_BYTES-wide words, buffers them in
// a word FIFO and presents them on a valid/ready interface.
// Optional feature macro: BURST_WORD_PACKER_CHECKSUM_EN (appends a mod-256
// checksum word after each burst).
// Ports:
//   clk, reset       : rising-edge clock, synchronous active-low reset
//   i_valid, Din     : byte strobe and byte from upstream
//   busy             : upstream must not start a new burst
//   o_valid, o_ready : output handshake
//   o_data, o_bytes  : packed word (first byte in [7:0]) and its valid byte count
//   o_last           : final word of the burst
//   o_err            : sticky FIFO overflow
module burst_word_packer
    import burst_pack_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_valid,
    input  logic [BYTE_W-1:0]                     Din,
    output logic                                  busy,
    output logic                                  o_valid,
    input  logic                                  o_ready,
    output logic [BYTE_W*WORD_BYTES-1:0]          o_data,
    output logic [count_width(WORD_BYTES)-1:0]    o_bytes,
    output logic                                  o_last,
    output logic                                  o_err
);

    localparam int unsigned CNT_W   = count_width(WORD_BYTES);
    localparam int unsigned DATA_W  = BYTE_W * WORD_BYTES;
    localparam int unsigned ENTRY_W = 1 + CNT_W + DATA_W;

`ifdef BURST_WORD_PACKER_CHECKSUM_EN
    localparam logic FLUSH_LAST = 1'b0;
`else
    localparam logic FLUSH_LAST = 1'b1;
`endif

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [WORD_BYTES-1:0][BYTE_W-1:0]    r_pack;
    logic [WORD_BYTES-1:0][BYTE_W-1:0]    w_pack_nxt;
    logic [CNT_W-1:0]                     r_count;
    logic [CNT_W-1:0]                     w_count_nxt;
    logic                                 r_busy;
    logic                                 r_err;
    logic                                 w_push;
    logic [ENTRY_W-1:0]                   w_push_data;
    logic [ENTRY_W-1:0]                   w_head;
    logic                                 w_pop;
    logic                                 w_full;
    logic                                 w_empty;
    logic                                 w_empty_nxt;
    logic                                 w_drop;
`ifdef BURST_WORD_PACKER_CHECKSUM_EN
    logic [BYTE_W-1:0]                    r_sum;
    logic [BYTE_W-1:0]                    w_sum_nxt;
`endif

    // Next-state, pack register update and FIFO push request.
    always_comb begin
        w_state_nxt = r_state;
        w_pack_nxt  = r_pack;
        w_count_nxt = r_count;
        w_push      = 1'b0;
        w_push_data = {1'b0, r_count, r_pack};
`ifdef BURST_WORD_PACKER_CHECKSUM_EN
        w_sum_nxt   = r_sum;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_pack_nxt    = '0;
                    w_pack_nxt[0] = Din;
                    w_count_nxt   = CNT_W'(1);
                    w_state_nxt   = ST_PACK;
`ifdef BURST_WORD_PACKER_CHECKSUM_EN
                    w_sum_nxt     = Din;
`endif
                end
            end
            ST_PACK: begin
                if (i_valid) begin
                    // A full word waits here so the burst end can still mark it last.
                    if (r_count == CNT_W'(WORD_BYTES)) begin
                        w_push        = 1'b1;
                        w_push_data   = {1'b0, r_count, r_pack};
                        w_pack_nxt    = '0;
                        w_pack_nxt[0] = Din;
                        w_count_nxt   = CNT_W'(1);
                    end else begin
                        w_pack_nxt[r_count[CNT_W-2:0]] = Din;
                        w_count_nxt                    = r_count + CNT_W'(1);
                    end
`ifdef BURST_WORD_PACKER_CHECKSUM_EN
                    w_sum_nxt = r_sum + Din;
`endif
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_push      = 1'b1;
                w_push_data = {FLUSH_LAST, r_count, r_pack};
`ifdef BURST_WORD_PACKER_CHECKSUM_EN
                w_state_nxt = ST_CSUM;
`else
                w_state_nxt = ST_IDLE;
`endif
            end
`ifdef BURST_WORD_PACKER_CHECKSUM_EN
            ST_CSUM: begin
                w_push      = 1'b1;
                w_push_data = {1'b1, CNT_W'(1), DATA_W'(r_sum)};
                w_state_nxt = ST_IDLE;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_pop  = ~w_empty & o_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    // State, pack register, busy and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pack  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pack  <= w_pack_nxt;
            r_count <= w_count_nxt;
            // Built from next-cycle values so busy tracks the first byte and last pop without lag.
            r_busy  <= (w_state_nxt != ST_IDLE) | ~w_empty_nxt;
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef BURST_WORD_PACKER_CHECKSUM_EN
    // Burst byte sum for the trailing checksum word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum_nxt;
        end
    end
`endif

    word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_data      (w_push_data),
        .i_pop       (w_pop),
        .o_data      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_empty_nxt (w_empty_nxt)
    );

    assign busy                      = r_busy;
    assign o_err                     = r_err;
    assign o_valid                   = ~w_empty;
    assign {o_last, o_bytes, o_data} = w_head;

endmodule

// File: tb/tb_burst_word_packer.sv
// Self-checking bench for burst_word_packer: directed bursts from the test
// plan plus randomized bursts and backpressure against a burst-level model.
// A second instance with a 2-entry FIFO covers overflow.
`timescale 1ns/1ps
module tb_burst_word_packer;
    import burst_pack_pkg::*;

    localparam int unsigned WB   = 4;
    localparam int unsigned CW   = count_width(WB);
    localparam int unsigned DW   = 8 * WB;
`ifdef BURST_WORD_PACKER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] n;
        logic          l;
    } word_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid, i_valid2;
    logic [7:0]    din;
    logic          busy, busy2;
    logic          o_valid, o_valid2;
    logic          o_ready, o_ready2;
    logic [DW-1:0] o_data, o_data2;
    logic [CW-1:0] o_bytes, o_bytes2;
    logic          o_last, o_last2;
    logic          o_err, o_err2;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            rdy_mode = 0;
    word_t         exp_q [$];
    logic [7:0]    bbuf [16];
    int            blen = 0;

    always #5 clk = ~clk;

    burst_word_packer #(.WORD_BYTES(WB), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .Din(din), .busy(busy),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_bytes(o_bytes),
        .o_last(o_last), .o_err(o_err)
    );

    burst_word_packer #(.WORD_BYTES(WB), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .i_valid(i_valid2), .Din(din), .busy(busy2),
        .o_valid(o_valid2), .o_ready(o_ready2), .o_data(o_data2), .o_bytes(o_bytes2),
        .o_last(o_last2), .o_err(o_err2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected words for bbuf[0..blen-1]: WB-byte chunks, last chunk flagged (or checksum word).
    task automatic model_burst();
        word_t      w;
        logic [7:0] sum;
        w   = '0;
        sum = '0;
        for (int i = 0; i < blen; i++) begin
            w.d[8*(i%WB) +: 8] = bbuf[i];
            sum = sum + bbuf[i];
            if ((i % WB) == WB - 1 || i == blen - 1) begin
                w.n = CW'((i % WB) + 1);
                w.l = (i == blen - 1) && !CSUM;
                exp_q.push_back(w);
                w = '0;
            end
        end
        if (CSUM) begin
            w      = '0;
            w.d[7:0] = sum;
            w.n    = CW'(1);
            w.l    = 1'b1;
            exp_q.push_back(w);
        end
    endtask

    // Called at posedge+1 with the packer idle.
    task automatic send_burst(input bit to2);
        model_burst();
        for (int i = 0; i < blen; i++) begin
            i_valid = 1'b1;
            din     = bbuf[i];
            if (to2) i_valid2 = 1'b1;
            @(posedge clk); #1;
            if (i == 0) check_eq("busy_rise", busy, 1);
        end
        i_valid  = 1'b0;
        i_valid2 = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (busy && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, "_busy_fall"}, busy, 0);
        check_eq({tag, "_words_left"}, exp_q.size(), 0);
        check_eq({tag, "_valid_idle"}, o_valid, 0);
        check_eq({tag, "_err"}, o_err, 0);
    endtask

    // Ready pattern for the main instance.
    initial begin
        o_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       o_ready = 1'b0;
                1:       o_ready = 1'b1;
                default: o_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: transfers seen here complete on the following rising edge.
    logic [DW-1:0] prev_d;
    bit            prev_hold = 1'b0;
    always @(negedge clk) begin
        word_t w;
        if (reset) begin
            if (prev_hold && o_valid) check_eq("hold_stable", o_data, prev_d);
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_word_valid", o_valid, 0);
                end else begin
                    w = exp_q.pop_front();
                    check_eq("word_data", o_data, w.d);
                    check_eq("word_bytes", o_bytes, w.n);
                    check_eq("word_last", o_last, w.l);
                end
            end
            prev_hold = o_valid && !o_ready;
            prev_d    = o_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w2_exp [2];
        reset    = 1'b0;
        i_valid  = 1'b0;
        i_valid2 = 1'b0;
        o_ready2 = 1'b0;
        din      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_data", o_data, 0);
        check_eq("rst_bytes", o_bytes, 0);
        check_eq("rst_last", o_last, 0);
        check_eq("rst_err", o_err, 0);
        check_eq("rst2_busy", busy2, 0);
        check_eq("rst2_valid", o_valid2, 0);
        check_eq("rst2_err", o_err2, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 8 bytes 0x01..0x08 with ready high.
        rdy_mode = 1;
        blen = 8;
        for (int i = 0; i < 8; i++) bbuf[i] = 8'(i + 1);
        send_burst(1'b0);
        wait_idle("b8");

        // Short burst AA BB CC.
        blen = 3;
        bbuf[0] = 8'hAA; bbuf[1] = 8'hBB; bbuf[2] = 8'hCC;
        send_burst(1'b0);
        wait_idle("b3");

        // 16 bytes held with ready low; the 2-entry instance overflows.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        blen = 16;
        for (int i = 0; i < 16; i++) bbuf[i] = 8'(8'h10 + i);
        send_burst(1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("held_err", o_err, 0);
        check_eq("held_busy", busy, 1);
        check_eq("held_valid", o_valid, 1);
        check_eq("held_head", o_data, 32'h13121110);
        check_eq("ovf_err", o_err2, 1);
        check_eq("ovf_busy", busy2, 1);
        rdy_mode = 1;
        wait_idle("b16");
        w2_exp[0] = 32'h13121110;
        w2_exp[1] = 32'h17161514;
        for (int k = 0; k < 2; k++) begin
            check_eq("ovf_valid", o_valid2, 1);
            check_eq("ovf_data", o_data2, w2_exp[k]);
            check_eq("ovf_bytes", o_bytes2, 4);
            check_eq("ovf_last", o_last2, 0);
            o_ready2 = 1'b1;
            @(posedge clk); #1;
            o_ready2 = 1'b0;
        end
        check_eq("ovf_drained", o_valid2, 0);
        check_eq("ovf_err_sticky", o_err2, 1);
        @(posedge clk); #1;
        check_eq("ovf_busy_fall", busy2, 0);

        // Reset after 5 bytes of a burst.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            din     = 8'($urandom);
            @(posedge clk); #1;
        end
        check_eq("mid_valid", o_valid, 1);
        reset   = 1'b0;
        i_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_valid", o_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_data", o_data, 0);
        check_eq("mid_rst_err2", o_err2, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        rdy_mode = 1;
        blen = 1;
        bbuf[0] = 8'h5A;
        send_burst(1'b0);
        wait_idle("b1");

        // FF 02: checksum wraps to 01 when the feature is built in.
        blen = 2;
        bbuf[0] = 8'hFF; bbuf[1] = 8'h02;
        send_burst(1'b0);
        wait_idle("b2");

        // Random bursts under random backpressure.
        for (int t = 0; t < 40; t++) begin
            rdy_mode = int'($urandom_range(1, 2));
            blen     = int'($urandom_range(1, 16));
            for (int i = 0; i < blen; i++) bbuf[i] = 8'($urandom);
            send_burst(1'b0);
            wait_idle("rnd");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_word_packer.md
Name: burst_word_packer

Overview:
- Downstream consumer of the byte-reversal stack stage. Takes its byte burst (`i_valid`/`Din`, up to 16 bytes, no stall capability) and packs bytes into `WORD_BYTES`-wide words.
- Buffers the packed words in a word FIFO and presents them on a valid/ready output interface.
- Drives `busy` back upstream so a new burst only starts when the packer can absorb it without loss.

Parameters:
- `WORD_BYTES`, 4, bytes per output word (power of 2, ≥2).
- `FIFO_DEPTH`, 8, word FIFO entries (power of 2; must be ≥ 16/`WORD_BYTES`, +1 when `CHECKSUM_EN`).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` rising edge).
- `i_valid`  in  1  byte strobe from upstream stage; `Din` is sampled on any rising edge where it is 1.
- `Din`  in  8  input byte.
- `busy`  out  1  1 = upstream must not start a new burst.
- `o_valid`  out  1  output word available.
- `o_ready`  in  1  downstream accepts word (transfer when `o_valid` & `o_ready`).
- `o_data`  out  8*`WORD_BYTES`  packed word; first-received byte in bits [7:0].
- `o_bytes`  out  clog2(`WORD_BYTES`)+1  number of valid bytes in `o_data` (1..`WORD_BYTES`).
- `o_last`  out  1  final word of burst.
- `o_err`  out  1  sticky overflow flag.

Behaviour:
- Reset (`reset`=0 at posedge): state IDLE, pack register and count cleared, FIFO emptied.
  - All outputs 0 during and after reset: `busy`, `o_valid`, `o_data`, `o_bytes`, `o_last`, `o_err`.
  - Reset mid-burst or mid-drain discards all held data; no partial word is emitted.
- States: IDLE, PACK, FLUSH.
- IDLE:
  - `i_valid`=1 loads `Din` into byte lane 0, count=1, goes to PACK.
- PACK:
  - `i_valid`=1 with count<`WORD_BYTES`: byte goes to lane[count], count+1.
  - `i_valid`=1 with count=`WORD_BYTES`: push register (`o_last`=0, `o_bytes`=`WORD_BYTES`), new byte goes to lane 0, count=1.
  - `i_valid`=0 (end of burst): go to FLUSH.
- FLUSH:
  - Push register with `o_last`=1, `o_bytes`=count; unused lanes are 0; return to IDLE.
  - The last word therefore enters the FIFO 2 cycles after the final byte is sampled.
- A full register is held, not pushed, until the next byte or burst end. This ensures `o_last` lands on the correct word when the burst length is a multiple of `WORD_BYTES`.
- Output interface:
  - FIFO head drives `o_data`/`o_bytes`/`o_last` directly; `o_valid` = FIFO not empty.
  - Pop on `o_valid`&`o_ready`; simultaneous push and pop allowed at any occupancy.
  - `o_data` is stable while `o_valid`=1 and `o_ready`=0.
- `busy` = (state ≠ IDLE) | FIFO not empty, registered.
  - Rises the cycle after the first byte is sampled.
  - Falls the cycle after the last word pops.
- Overflow: a push while FIFO is full is dropped and `o_err` sets to 1, held until reset. Packing continues normally.
- Byte count never exceeds `WORD_BYTES`; FIFO pointers wrap modulo `FIFO_DEPTH` with an extra MSB for full/empty.

Optional Feature:
- Macro `BURST_WORD_PACKER_CHECKSUM_EN`.
- Defined:
  - Adds state CSUM after FLUSH. The FLUSH word is pushed with `o_last`=0.
  - CSUM pushes one extra word: byte 0 = 8-bit mod-256 sum of all burst bytes, other lanes 0, `o_bytes`=1, `o_last`=1.
  - The sum accumulator clears on entry to PACK from IDLE.
- Undefined: no CSUM state and no accumulator; FLUSH word carries `o_last`=1.

Decomposition:
- Package `burst_pack_pkg`:
  - state enum (IDLE/PACK/FLUSH/CSUM);
  - `MAX_BURST`=16;
  - byte width constant 8;
  - count-width function.
- One sub-module `word_fifo`: parameterised width/depth synchronous FIFO with push, pop, full, empty, head data. It stores {`o_last`, `o_bytes`, `o_data`} and shares the same `clk`/active-low synchronous `reset`.

Test Plan:
- Burst 0x01..0x08 (8 bytes), `o_ready`=1 → words 0x04030201 (`o_bytes`=4, `o_last`=0), 0x08070605 (`o_bytes`=4, `o_last`=1); `busy` returns 0 afterwards.
- Burst 0xAA,0xBB,0xCC → single word 0x00CCBBAA, `o_bytes`=3, `o_last`=1.
- Burst of 16 bytes 0x10..0x1F with `o_ready`=0 → 4 words held, `o_err`=0, `busy`=1. Raise `o_ready`: words 0x13121110 .. 0x1F1E1D1C, last flagged.
- `FIFO_DEPTH`=2, 16-byte burst, `o_ready`=0 → `o_err`=1 and stays 1; the first 2 words are intact on drain.
- `reset`=0 asserted after 5 bytes of a burst → `o_valid`=0, `busy`=0 next cycle; a following 1-byte burst 0x5A yields 0x0000005A, `o_bytes`=1, `o_last`=1.
- With `BURST_WORD_PACKER_CHECKSUM_EN`, burst 0xFF,0x02 → data word 0x000002FF (`o_last`=0), then checksum word 0x00000001 (`o_bytes`=1, `o_last`=1).
